mmu_pfault_irq_ctrl: RTL

Responder end of the per-vFPGA MMU page-fault protocol. It accepts read and write page-fault notifications from the TLB FSMs, arbitrates between them and latches the fault into host-visible status. It then raises a host interrupt, waits for the driver's restart/abort decision and returns that decision to the faulting FSM on its pfault control channel. There is one instance per vFPGA, next to the region MMU.

---
 rtl/mmu_pfault_irq_ctrl_pkg.sv | 29 ++
 rtl/mmu_pfault_irq_ctrl_if.sv | 48 ++++
 rtl/mmu_pfault_irq_ctrl_rr_arb.sv | 32 +++
 rtl/mmu_pfault_irq_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mmu_pfault_irq_ctrl_pkg.sv
// Shared types for the MMU page-fault responder: latched fault record, FSM states, ctrl bit positions.
package mmu_pfault_irq_ctrl_pkg;

    localparam int PF_VADDR_W = 48;
    localparam int PF_LEN_W   = 28;
    localparam int PF_PID_W   = 6;

    localparam int PF_CTRL_RESTART_BIT = 0;
    localparam int PF_CTRL_ABORT_BIT   = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IRQ,
        ST_WAIT,
        ST_RESP
    } pf_state_t;

    typedef struct packed {
        logic [PF_VADDR_W-1:0] vaddr;
        logic [PF_LEN_W-1:0]   rng;
        logic [PF_PID_W-1:0]   pid;
        logic                  wr;
    } pfault_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mmu_pfault_irq_ctrl_if.sv
// Bundle of fault notification, host irq/ctrl, response and status signals of one vFPGA responder.
interface mmu_pfault_irq_ctrl_if #(
    parameter int VADDR_BITS = 48,
    parameter int LEN_BITS   = 28,
    parameter int PID_BITS   = 6
);
    logic                  pf_rd_valid, pf_rd_ready;
    logic [VADDR_BITS-1:0] pf_rd_vaddr;
    logic [LEN_BITS-1:0]   pf_rd_rng;
    logic [PID_BITS-1:0]   pf_rd_pid;
    logic                  pf_wr_valid, pf_wr_ready;
    logic [VADDR_BITS-1:0] pf_wr_vaddr;
    logic [LEN_BITS-1:0]   pf_wr_rng;
    logic [PID_BITS-1:0]   pf_wr_pid;
    logic                  irq_valid, irq_ready;
    logic                  ctrl_valid;
    logic [1:0]            ctrl_data;
    logic                  rsp_rd_valid, rsp_rd_ready;
    logic                  rsp_wr_valid, rsp_wr_ready;
    logic                  rsp_restart;
    logic [VADDR_BITS-1:0] stat_vaddr;
    logic [LEN_BITS-1:0]   stat_rng;
    logic [PID_BITS-1:0]   stat_pid;
    logic                  stat_wr;
    logic [3:0]            stat_id;
    logic                  stat_timeout;
    logic [31:0]           stat_fault_cnt;
    logic [7:0]            stat_drop_cnt;

    modport slave (
        input  pf_rd_valid, pf_rd_vaddr, pf_rd_rng, pf_rd_pid,
        input  pf_wr_valid, pf_wr_vaddr, pf_wr_rng, pf_wr_pid,
        input  irq_ready, ctrl_valid, ctrl_data, rsp_rd_ready, rsp_wr_ready,
        output pf_rd_ready, pf_wr_ready, irq_valid, rsp_rd_valid, rsp_wr_valid, rsp_restart,
        output stat_vaddr, stat_rng, stat_pid, stat_wr, stat_id, stat_timeout,
        output stat_fault_cnt, stat_drop_cnt
    );

    modport master (
        output pf_rd_valid, pf_rd_vaddr, pf_rd_rng, pf_rd_pid,
        output pf_wr_valid, pf_wr_vaddr, pf_wr_rng, pf_wr_pid,
        output irq_ready, ctrl_valid, ctrl_data, rsp_rd_ready, rsp_wr_ready,
        input  pf_rd_ready, pf_wr_ready, irq_valid, rsp_rd_valid, rsp_wr_valid, rsp_restart,
        input  stat_vaddr, stat_rng, stat_pid, stat_wr, stat_id, stat_timeout,
        input  stat_fault_cnt, stat_drop_cnt
    );

endinterface

// File: rtl/mmu_pfault_irq_ctrl_rr_arb.sv
// Two-input round-robin grant between read and write faults; the last-served side loses a tie.
module pfault_rr_arb (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic rd_valid_i,
    input  logic wr_valid_i,
    output logic rd_gnt_o,
    output logic wr_gnt_o
);
    logic last_wr_q, last_wr_d;

    // A grant is a handshake because ready is driven straight from the grant.
    assign rd_gnt_o = en_i & rd_valid_i & (~wr_valid_i | last_wr_q);
    assign wr_gnt_o = en_i & wr_valid_i & (~rd_valid_i | ~last_wr_q);

    always_comb begin
        last_wr_d = last_wr_q;
        if (rd_gnt_o)
            last_wr_d = 1'b0;
        else if (wr_gnt_o)
            last_wr_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            last_wr_q <= 1'b1;
        else
            last_wr_q <= last_wr_d;
    end

endmodule

// File: rtl/mmu_pfault_irq_ctrl.sv
// Per-vFPGA page-fault responder: arbitrate faults, raise irq, relay host restart/abort to the faulting FSM.
// Optional watchdog abort in ST_WAIT is enabled by defining MMU_PFAULT_TIMEOUT_EN.
module mmu_pfault_irq_ctrl
    import mmu_pfault_irq_ctrl_pkg::*;
#(
    parameter int ID_REG         = 0,
    parameter int VADDR_BITS     = 48,
    parameter int LEN_BITS       = 28,
    parameter int PID_BITS       = 6,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input logic aclk,
    input logic areset,
    mmu_pfault_irq_ctrl_if.slave bus
);

    if (TIMEOUT_CYCLES < 1 || ID_REG < 0 || ID_REG > 15) begin : g_param_chk
        $error("mmu_pfault_irq_ctrl: TIMEOUT_CYCLES must be >= 1 and ID_REG in 0..15");
    end

    pf_state_t   state_q, state_d;
    pfault_t     fault_q, fault_in;
    logic        restart_q, restart_d;
    logic [31:0] fault_cnt_q;
    logic [7:0]  drop_cnt_q;
    logic        rd_gnt, wr_gnt, accept, ctrl_ok, rsp_ready;

    pfault_rr_arb u_arb (
        .clk_i      (aclk),
        .rst_i      (areset),
        .en_i       (state_q == ST_IDLE),
        .rd_valid_i (bus.pf_rd_valid),
        .wr_valid_i (bus.pf_wr_valid),
        .rd_gnt_o   (rd_gnt),
        .wr_gnt_o   (wr_gnt)
    );

    assign accept    = rd_gnt | wr_gnt;
    assign ctrl_ok   = (state_q == ST_WAIT) && bus.ctrl_valid && (bus.ctrl_data != 2'b00);
    assign rsp_ready = fault_q.wr ? bus.rsp_wr_ready : bus.rsp_rd_ready;

    always_comb begin
        fault_in.vaddr = PF_VADDR_W'(bus.pf_rd_vaddr);
        fault_in.rng   = PF_LEN_W'(bus.pf_rd_rng);
        fault_in.pid   = PF_PID_W'(bus.pf_rd_pid);
        fault_in.wr    = 1'b0;
        if (wr_gnt) begin
            fault_in.vaddr = PF_VADDR_W'(bus.pf_wr_vaddr);
            fault_in.rng   = PF_LEN_W'(bus.pf_wr_rng);
            fault_in.pid   = PF_PID_W'(bus.pf_wr_pid);
            fault_in.wr    = 1'b1;
        end
    end

`ifdef MMU_PFAULT_TIMEOUT_EN
    logic [31:0] wait_cnt_q;
    logic        timeout_q, tmo_fire;

    assign tmo_fire = (state_q == ST_WAIT) && !ctrl_ok && (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q == ST_IRQ && bus.irq_ready)
                wait_cnt_q <= '0;
            else if (state_q == ST_WAIT)
                wait_cnt_q <= wait_cnt_q + 32'd1;
            if (accept)
                timeout_q <= 1'b0;
            else if (tmo_fire)
                timeout_q <= 1'b1;
        end
    end

    assign bus.stat_timeout = timeout_q;
`else
    logic tmo_fire;
    assign tmo_fire         = 1'b0;
    assign bus.stat_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        restart_d = restart_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_IRQ;
            ST_IRQ:  if (bus.irq_ready) state_d = ST_WAIT;
            ST_WAIT: begin
                // Abort has priority when the host sets both bits.
                if (ctrl_ok) begin
                    state_d   = ST_RESP;
                    restart_d = ~bus.ctrl_data[PF_CTRL_ABORT_BIT] & bus.ctrl_data[PF_CTRL_RESTART_BIT];
                end else if (tmo_fire) begin
                    state_d   = ST_RESP;
                    restart_d = 1'b0;
                end
            end
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            restart_q   <= 1'b0;
            fault_q     <= '0;
            fault_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            restart_q <= restart_d;
            if (accept) begin
                fault_q     <= fault_in;
                fault_cnt_q <= fault_cnt_q + 32'd1;
            end
            if (bus.ctrl_valid && !ctrl_ok)
                drop_cnt_q <= sat_inc8(drop_cnt_q);
        end
    end

    assign bus.pf_rd_ready    = rd_gnt;
    assign bus.pf_wr_ready    = wr_gnt;
    assign bus.irq_valid      = (state_q == ST_IRQ);
    assign bus.rsp_rd_valid   = (state_q == ST_RESP) && !fault_q.wr;
    assign bus.rsp_wr_valid   = (state_q == ST_RESP) && fault_q.wr;
    assign bus.rsp_restart    = restart_q;
    assign bus.stat_vaddr     = VADDR_BITS'(fault_q.vaddr);
    assign bus.stat_rng       = LEN_BITS'(fault_q.rng);
    assign bus.stat_pid       = PID_BITS'(fault_q.pid);
    assign bus.stat_wr        = fault_q.wr;
    assign bus.stat_id        = 4'(ID_REG);
    assign bus.stat_fault_cnt = fault_cnt_q;
    assign bus.stat_drop_cnt  = drop_cnt_q;

endmodule
